complex_addsub_drain: RTL and testbench

- Receiving end of the complex FP add/sub result stream. Captures each {re, im} result on `in_valid`; the producer has no backpressure.
- Buffers results in a FWFT FIFO and presents them downstream as a ready/valid master.
- Issues credits upstream so the add/sub pipeline is never launched without guaranteed FIFO space. This keeps STFT butterfly results lossless under downstream stalls.

---
 rtl/complex_addsub_drain.sv | 136 +++++++++++++
 tb/tb_complex_addsub_drain.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_addsub_drain.sv
// Receive side of the complex FP add/sub result stream: credit-gated launch, FWFT FIFO, ready/valid output.
// Optional delivered-result counter is built when DRAIN_PKT_CNT_EN is defined; otherwise pkt_cnt is tied to 0.
`timescale 1ns/1ps

module complex_addsub_drain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_req,
  output logic              issue_ok,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_re,
  output logic [DATA_W-1:0] m_im,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  inflight,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
  output logic [31:0]       pkt_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_re_q [DEPTH];
  logic [DATA_W-1:0] mem_im_q [DEPTH];

  logic launch;
  logic ret;
  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic ovf_evt;
  logic unf_evt;

  // Credits cover both buffered and still-in-flight results, so a launch always has a slot waiting.
  assign issue_ok = ({1'b0, level_q} + {1'b0, inflight_q}) < DEPTH_EXT;

  assign m_valid   = (level_q != '0);
  assign m_re      = m_valid ? mem_re_q[rd_ptr_q] : '0;
  assign m_im      = m_valid ? mem_im_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign inflight  = inflight_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    launch  = issue_req & issue_ok;
    ret     = in_valid;
    push    = in_valid;
    pop     = m_valid & m_ready;
    full    = (level_q == DEPTH_CNT);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_en   = push & (~full | pop);
    ovf_evt = push & full & ~pop;
    unf_evt = ret & ~launch & (inflight_q == '0);

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + CNT_W'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - CNT_W'(1);
    end

    inflight_d = inflight_q;
    if (launch && !ret) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (ret && !launch && inflight_q != '0) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    // A fresh error event takes priority over a simultaneous clear.
    overflow_d  = ovf_evt | (overflow_q  & ~err_clr);
    underflow_d = unf_evt | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re_q[wr_ptr_q] <= in_re;
      mem_im_q[wr_ptr_q] <= in_im;
    end
  end

`ifdef DRAIN_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (pop) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_complex_addsub_drain.sv
// Self-checking bench for complex_addsub_drain: scoreboard queue of expected {re,im} words checked on every pop.
`timescale 1ns/1ps

module tb_complex_addsub_drain;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_req;
  logic              issue_ok;
  logic              in_valid;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_re;
  logic [DATA_W-1:0] m_im;
  logic [CNT_W-1:0]  level;
  logic [CNT_W-1:0]  inflight;
  logic              overflow;
  logic              underflow;
  logic              err_clr;
  logic [31:0]       pkt_cnt;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          popCount    = 0;
  logic [63:0] sbQ[$];

  always #5 clk = ~clk;

  complex_addsub_drain #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_req(issue_req),
    .issue_ok (issue_ok),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .level    (level),
    .inflight (inflight),
    .overflow (overflow),
    .underflow(underflow),
    .err_clr  (err_clr),
    .pkt_cnt  (pkt_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expPkt(input int n);
`ifdef DRAIN_PKT_CNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  // Every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      checkOutput("sb_has_entry", 64'(sbQ.size() > 0), 64'd1);
      if (sbQ.size() > 0) begin
        checkOutput("pop_data", {m_re, m_im}, sbQ.pop_front());
      end
      popCount++;
    end
  end

  // One call drives one cycle of inputs, changed just after the active edge.
  task automatic applyStimulus(input logic req, input logic vld, input logic [31:0] re,
                               input logic [31:0] im, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    issue_req = req;
    in_valid  = vld;
    in_re     = re;
    in_im     = im;
    m_ready   = rdy;
    err_clr   = clr;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic sendResult(input logic [31:0] re, input logic [31:0] im, input logic rdy);
    sbQ.push_back({re, im});
    applyStimulus(1'b0, 1'b1, re, im, rdy, 1'b0);
  endtask

  task automatic launchOps(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    issue_req = 1'b0;
    in_valid  = 1'b0;
    m_ready   = 1'b0;
    err_clr   = 1'b0;
    sbQ.delete();
    popCount  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drainAll(input string tag);
    int cyc;
    for (cyc = 0; cyc < 40; cyc++) begin
      idle(1'b1);
      @(negedge clk);
      if (level == '0) break;
    end
    checkOutput({tag, "_level"}, 64'(level), 64'd0);
    checkOutput({tag, "_sb_empty"}, 64'(sbQ.size()), 64'd0);
    checkOutput({tag, "_issue_ok"}, 64'(issue_ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] testRe [3];
    logic [31:0] testIm [3];
    bit          retSched [80];
    int          launches;
    int          retIdx;
    logic        v;
    logic [31:0] r;

    testRe = '{32'h3F800000, 32'h40400000, 32'hBF800000};
    testIm = '{32'h40000000, 32'h40800000, 32'h00000000};

    rst_n = 1'b0; issue_req = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
    m_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_m_valid",   64'(m_valid),   64'd0);
    checkOutput("rst_issue_ok",  64'(issue_ok),  64'd1);
    checkOutput("rst_level",     64'(level),     64'd0);
    checkOutput("rst_inflight",  64'(inflight),  64'd0);
    checkOutput("rst_flags",     64'({overflow, underflow}), 64'd0);
    checkOutput("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
    checkOutput("rst_data",      {m_re, m_im},   64'd0);

    // Three launches, results returned in order with downstream always ready.
    launchOps(3, 1'b1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("launch3_inflight", 64'(inflight), 64'd3);
    for (int i = 0; i < 3; i++) begin
      sendResult(testRe[i], testIm[i], 1'b1);
      idle(1'b1);
      @(negedge clk);
      checkOutput("lat_m_valid", 64'(m_valid), 64'd1);
      checkOutput("lat_level",   64'(level),   64'd1);
    end
    idle(1'b1);
    @(negedge clk);
    checkOutput("basic_inflight",  64'(inflight),   64'd0);
    checkOutput("basic_level",     64'(level),      64'd0);
    checkOutput("basic_sb_empty",  64'(sbQ.size()), 64'd0);
    checkOutput("basic_underflow", 64'(underflow),  64'd0);
    checkOutput("basic_pkt_cnt",   64'(pkt_cnt),    64'(expPkt(popCount)));

    // Continuous requests with a stalled sink: credits must cap launches at DEPTH.
    launches = 0;
    retIdx   = 0;
    for (int c = 0; c < 80; c++) retSched[c] = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      v = retSched[cyc];
      r = 32'h41000000 + 32'(retIdx);
      if (v) begin
        sbQ.push_back({r, ~r});
        retIdx++;
      end
      applyStimulus(1'b1, v, r, ~r, 1'b0, 1'b0);
      @(negedge clk);
      if (issue_ok) begin
        launches++;
        retSched[cyc + 12] = 1'b1;
      end
    end
    idle(1'b0);
    @(negedge clk);
    checkOutput("credit_launches", 64'(launches), 64'd16);
    checkOutput("credit_issue_ok", 64'(issue_ok), 64'd0);
    checkOutput("credit_level",    64'(level),    64'd16);
    checkOutput("credit_inflight", 64'(inflight), 64'd0);
    checkOutput("credit_overflow", 64'(overflow), 64'd0);
    drainAll("credit_drain");

    // Fill, then push into a full FIFO with the sink stalled.
    launchOps(16, 1'b0);
    for (int i = 0; i < 16; i++) sendResult(32'h42000000 + 32'(i), 32'hC2000000 + 32'(i), 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    checkOutput("ovf_flag",      64'(overflow),  64'd1);
    checkOutput("ovf_level",     64'(level),     64'd16);
    checkOutput("ovf_underflow", 64'(underflow), 64'd1);
    checkOutput("ovf_head",      {m_re, m_im},   sbQ[0]);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    checkOutput("clr_vs_event", 64'(overflow), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    checkOutput("clr_flags", 64'({overflow, underflow}), 64'd0);

    // Full FIFO with simultaneous push and pop: the new word lands at the tail.
    sendResult(32'h44440000, 32'h55550000, 1'b1);
    idle(1'b0);
    @(negedge clk);
    checkOutput("fullpp_level",    64'(level),    64'd16);
    checkOutput("fullpp_overflow", 64'(overflow), 64'd0);
    drainAll("fullpp_drain");
    checkOutput("fullpp_pkt_cnt", 64'(pkt_cnt), 64'(expPkt(popCount)));

    // Reset while results are still outstanding; the late result is an underflow.
    launchOps(2, 1'b0);
    sendResult(32'h11110000, 32'h22220000, 1'b0);
    idle(1'b0);
    @(negedge clk);
    checkOutput("pre_rst_inflight", 64'(inflight), 64'd1);
    doReset();
    @(negedge clk);
    checkOutput("mid_rst_level",    64'(level),    64'd0);
    checkOutput("mid_rst_inflight", 64'(inflight), 64'd0);
    sendResult(32'h33330000, 32'h44440000, 1'b0);
    idle(1'b0);
    @(negedge clk);
    checkOutput("late_underflow", 64'(underflow), 64'd1);
    checkOutput("late_level",     64'(level),     64'd1);
    checkOutput("late_pkt_cnt",   64'(pkt_cnt),   64'd0);
    drainAll("late_drain");

    // Deliver five results from a clean reset.
    doReset();
    launchOps(5, 1'b1);
    for (int i = 0; i < 5; i++) sendResult(32'h45000000 + 32'(i), 32'h46000000 - 32'(i), 1'b1);
    drainAll("pkt_drain");
    checkOutput("pkt_pops",      64'(popCount),  64'd5);
    checkOutput("pkt_cnt_value", 64'(pkt_cnt),   64'(expPkt(5)));
    checkOutput("pkt_flags",     64'({overflow, underflow}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
